// File: rtl/bpf_pkg.sv
// Shared types and widths for the BPF packet path: buffer lifecycle states and the
// accepted-length width derived from the packet memory byte address.
package bpf_pkg;

    localparam int unsigned PACKET_BYTE_ADDR_WIDTH = 12;
    localparam int unsigned PLEN_W = PACKET_BYTE_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLED   = 2'd1,
        ACCEPTED = 2'd2,
        REJECTED = 2'd3
    } buf_state_t;

endpackage

// File: rtl/ring_ptr.sv
// Modulo-N ring pointer: advances by one on adv and wraps from N-1 back to 0.
module ring_ptr #(
    parameter int unsigned N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    output logic [$clog2(N)-1:0] ptr
);

    localparam int unsigned W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + W'(1);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/packet_buf_ring.sv
// N-way packet buffer ring: each buffer cycles snooper fill -> CPU filter -> forwarder drain,
// in strict ring order, with rejected buffers recycled without forwarder involvement.
module packet_buf_ring
    import bpf_pkg::*;
#(
    parameter  int unsigned N_BUFS     = 3,
    parameter  int unsigned PLEN_WIDTH = PLEN_W,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned SELW       = $clog2(N_BUFS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snooper_done,
    output logic                  ready_for_snooper,
    output logic [SELW-1:0]       snooper_sel,
    output logic                  ready_for_cpu,
    output logic [SELW-1:0]       cpu_sel,
    input  logic                  cpu_acc,
    input  logic                  cpu_rej,
    input  logic [PLEN_WIDTH-1:0] cpu_len,
    output logic                  ready_for_forwarder,
    output logic [SELW-1:0]       forwarder_sel,
    output logic [PLEN_WIDTH-1:0] forwarder_len,
    input  logic                  forwarder_done,
    output logic [SELW:0]         occupancy,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  rej_count,
    output logic                  proto_err
);

    buf_state_t            state_q [N_BUFS];
    buf_state_t            state_d [N_BUFS];
    logic [PLEN_WIDTH-1:0] len_q   [N_BUFS];
    logic [PLEN_WIDTH-1:0] len_d   [N_BUFS];

    logic [SELW:0]        occ_q, occ_d;
    logic [CNT_WIDTH-1:0] drop_q, rej_q;
    logic                 proto_q;

    logic [SELW-1:0] sn_ptr, cpu_ptr, fwd_ptr;
    logic            sn_go, drop_ev, cpu_go, rej_ev, fwd_free, fwd_go;

    assign ready_for_snooper   = rst && (state_q[sn_ptr] == EMPTY);
    assign ready_for_cpu       = rst && (state_q[cpu_ptr] == FILLED);
    assign ready_for_forwarder = rst && (state_q[fwd_ptr] == ACCEPTED);

    assign sn_go    = snooper_done && ready_for_snooper;
    assign drop_ev  = snooper_done && !ready_for_snooper;
    assign cpu_go   = (cpu_acc || cpu_rej) && ready_for_cpu;
    // A simultaneous acc+rej resolves to reject.
    assign rej_ev   = cpu_go && cpu_rej;
    assign fwd_free = rst && (state_q[fwd_ptr] == REJECTED);
    assign fwd_go   = fwd_free || (forwarder_done && ready_for_forwarder);

    ring_ptr #(.N(N_BUFS)) u_sn_ptr  (.clk(clk), .rst(rst), .adv(sn_go),  .ptr(sn_ptr));
    ring_ptr #(.N(N_BUFS)) u_cpu_ptr (.clk(clk), .rst(rst), .adv(cpu_go), .ptr(cpu_ptr));
    ring_ptr #(.N(N_BUFS)) u_fwd_ptr (.clk(clk), .rst(rst), .adv(fwd_go), .ptr(fwd_ptr));

    // Agents sharing a buffer index never both act: each one requires a distinct state there.
    always_comb begin
        for (int unsigned i = 0; i < N_BUFS; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
        end
        if (sn_go) begin
            state_d[sn_ptr] = FILLED;
        end
        if (cpu_go) begin
            if (cpu_rej) begin
                state_d[cpu_ptr] = REJECTED;
            end else begin
                state_d[cpu_ptr] = ACCEPTED;
                len_d[cpu_ptr]   = cpu_len;
            end
        end
        if (fwd_go) begin
            state_d[fwd_ptr] = EMPTY;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({sn_go, fwd_go})
            2'b10:   occ_d = occ_q + (SELW + 1)'(1);
            2'b01:   occ_d = occ_q - (SELW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_BUFS; i++) begin
                state_q[i] <= EMPTY;
                len_q[i]   <= '0;
            end
            occ_q   <= '0;
            drop_q  <= '0;
            rej_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_BUFS; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
            end
            occ_q <= occ_d;
            if (drop_ev && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_WIDTH'(1);
            end
            if (rej_ev && (rej_q != '1)) begin
                rej_q <= rej_q + CNT_WIDTH'(1);
            end
            if (cpu_acc && cpu_rej) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign snooper_sel   = sn_ptr;
    assign cpu_sel       = cpu_ptr;
    assign forwarder_sel = fwd_ptr;
    assign forwarder_len = len_q[fwd_ptr];
    assign occupancy     = occ_q;
    assign drop_count    = drop_q;
    assign rej_count     = rej_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_packet_buf_ring.sv
// Scoreboard bench for packet_buf_ring: a 3-buffer instance for reset, overflow, ordering,
// concurrency and protocol-error scenarios, and a 5-buffer instance for ring wrap.
module tb_packet_buf_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int sel;
        int len;
    } exp_t;
    exp_t sbq[$];

    // 3-buffer instance
    logic        a_rst = 1'b0, a_sn_done = 1'b0, a_acc = 1'b0, a_rej = 1'b0, a_fwd_done = 1'b0;
    logic [12:0] a_cpu_len = '0;
    logic        a_rdy_sn, a_rdy_cpu, a_rdy_fwd, a_perr;
    logic [1:0]  a_sn_sel, a_cpu_sel, a_fwd_sel;
    logic [12:0] a_fwd_len;
    logic [2:0]  a_occ;
    logic [15:0] a_drop, a_rejc;

    packet_buf_ring #(.N_BUFS(3), .PLEN_WIDTH(13), .CNT_WIDTH(16)) u_dut3 (
        .clk(clk), .rst(a_rst), .snooper_done(a_sn_done), .ready_for_snooper(a_rdy_sn),
        .snooper_sel(a_sn_sel), .ready_for_cpu(a_rdy_cpu), .cpu_sel(a_cpu_sel),
        .cpu_acc(a_acc), .cpu_rej(a_rej), .cpu_len(a_cpu_len),
        .ready_for_forwarder(a_rdy_fwd), .forwarder_sel(a_fwd_sel),
        .forwarder_len(a_fwd_len), .forwarder_done(a_fwd_done), .occupancy(a_occ),
        .drop_count(a_drop), .rej_count(a_rejc), .proto_err(a_perr)
    );

    // 5-buffer instance
    logic        b_rst = 1'b0, b_sn_done = 1'b0, b_acc = 1'b0, b_rej = 1'b0, b_fwd_done = 1'b0;
    logic [12:0] b_cpu_len = '0;
    logic        b_rdy_sn, b_rdy_cpu, b_rdy_fwd, b_perr;
    logic [2:0]  b_sn_sel, b_cpu_sel, b_fwd_sel;
    logic [12:0] b_fwd_len;
    logic [3:0]  b_occ;
    logic [15:0] b_drop, b_rejc;

    packet_buf_ring #(.N_BUFS(5), .PLEN_WIDTH(13), .CNT_WIDTH(16)) u_dut5 (
        .clk(clk), .rst(b_rst), .snooper_done(b_sn_done), .ready_for_snooper(b_rdy_sn),
        .snooper_sel(b_sn_sel), .ready_for_cpu(b_rdy_cpu), .cpu_sel(b_cpu_sel),
        .cpu_acc(b_acc), .cpu_rej(b_rej), .cpu_len(b_cpu_len),
        .ready_for_forwarder(b_rdy_fwd), .forwarder_sel(b_fwd_sel),
        .forwarder_len(b_fwd_len), .forwarder_done(b_fwd_done), .occupancy(b_occ),
        .drop_count(b_drop), .rej_count(b_rejc), .proto_err(b_perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snoop_a();
        a_sn_done = 1'b1;
        tick();
        a_sn_done = 1'b0;
    endtask

    task automatic accept_a(input int len, input bit expect_fwd);
        if (expect_fwd) sbq.push_back('{sel: int'(a_cpu_sel), len: len});
        a_acc     = 1'b1;
        a_cpu_len = 13'(len);
        tick();
        a_acc = 1'b0;
    endtask

    // Wait (bounded) for the forwarder, compare against the scoreboard head, then drain.
    task automatic drain_a(input string tag);
        int   n = 0;
        exp_t e;
        while (!a_rdy_fwd && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (!a_rdy_fwd) begin
            failures++;
            $display("FAIL %s_fwd_wait: ready_for_forwarder=%b after %0d cycles, want 1",
                     tag, a_rdy_fwd, n);
        end else if (sbq.size() == 0) begin
            failures++;
            $display("FAIL %s_fwd_extra: forwarder got sel=%0d len=%0d, want nothing",
                     tag, a_fwd_sel, a_fwd_len);
        end else begin
            e = sbq.pop_front();
            if (a_fwd_sel !== 2'(e.sel) || a_fwd_len !== 13'(e.len)) begin
                failures++;
                $display("FAIL %s_fwd_data: got sel=%0d len=%0d, want sel=%0d len=%0d",
                         tag, a_fwd_sel, a_fwd_len, e.sel, e.len);
            end
            a_fwd_done = 1'b1;
            tick();
            a_fwd_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0;
        tick();
        tick();
        checks++; if ({a_rdy_sn, a_rdy_cpu, a_rdy_fwd} !== 3'b000) begin failures++;
            $display("FAIL rst_ready_low: got %b want 000", {a_rdy_sn, a_rdy_cpu, a_rdy_fwd}); end
        a_rst = 1'b1;
        #1;
        checks++; if ({a_rdy_sn, a_rdy_cpu, a_rdy_fwd} !== 3'b100) begin failures++;
            $display("FAIL rst_ready: got %b want 100", {a_rdy_sn, a_rdy_cpu, a_rdy_fwd}); end
        checks++; if (a_occ !== 3'd0) begin failures++;
            $display("FAIL rst_occ: got %0d want 0", a_occ); end
        checks++; if ({a_sn_sel, a_cpu_sel, a_fwd_sel} !== 6'd0) begin failures++;
            $display("FAIL rst_sel: got %0d/%0d/%0d want 0/0/0", a_sn_sel, a_cpu_sel, a_fwd_sel); end
        checks++; if (a_drop !== 16'd0 || a_rejc !== 16'd0 || a_perr !== 1'b0) begin failures++;
            $display("FAIL rst_stats: got drop=%0d rej=%0d perr=%b want 0/0/0", a_drop, a_rejc, a_perr); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_sn_sel !== 2'(i)) begin failures++;
                $display("FAIL fill_sel%0d: got %0d want %0d", i, a_sn_sel, i); end
            snoop_a();
            tick();
        end
        checks++; if (a_occ !== 3'd3) begin failures++;
            $display("FAIL fill_occ: got %0d want 3", a_occ); end
        checks++; if (a_rdy_sn !== 1'b0) begin failures++;
            $display("FAIL fill_rdy_sn: got %b want 0", a_rdy_sn); end
        checks++; if (a_rdy_cpu !== 1'b1 || a_cpu_sel !== 2'd0) begin failures++;
            $display("FAIL fill_cpu: got rdy=%b sel=%0d want rdy=1 sel=0", a_rdy_cpu, a_cpu_sel); end
    endtask

    task automatic test_overflow();
        snoop_a();
        tick();
        snoop_a();
        checks++; if (a_drop !== 16'd2) begin failures++;
            $display("FAIL ovf_drop: got %0d want 2", a_drop); end
        checks++; if (a_occ !== 3'd3 || a_sn_sel !== 2'd0) begin failures++;
            $display("FAIL ovf_state: got occ=%0d sn_sel=%0d want 3/0", a_occ, a_sn_sel); end
    endtask

    task automatic test_accept_reject();
        int n = 0;
        accept_a(64, 1'b1);
        checks++; if (a_rdy_fwd !== 1'b1 || a_cpu_sel !== 2'd1) begin failures++;
            $display("FAIL ar_after_acc: got rdy_fwd=%b cpu_sel=%0d want 1/1", a_rdy_fwd, a_cpu_sel); end
        a_rej = 1'b1;
        tick();
        a_rej = 1'b0;
        accept_a(1500, 1'b1);
        drain_a("ar_buf0");
        checks++; if (a_rdy_fwd !== 1'b0 || a_fwd_sel !== 2'd1) begin failures++;
            $display("FAIL ar_rej_hidden: got rdy=%b sel=%0d want 0/1", a_rdy_fwd, a_fwd_sel); end
        while (!a_rdy_fwd && n < 4) begin
            tick();
            n++;
        end
        checks++; if (n > 1 || a_fwd_sel !== 2'd2) begin failures++;
            $display("FAIL ar_autofree: got %0d cycles sel=%0d want <=1 cycle sel=2", n, a_fwd_sel); end
        drain_a("ar_buf2");
        checks++; if (a_rejc !== 16'd1) begin failures++;
            $display("FAIL ar_rej_count: got %0d want 1", a_rejc); end
        checks++; if (a_occ !== 3'd0 || a_rdy_sn !== 1'b1) begin failures++;
            $display("FAIL ar_empty: got occ=%0d rdy_sn=%b want 0/1", a_occ, a_rdy_sn); end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        snoop_a();
        snoop_a();
        accept_a(100, 1'b1);
        // buf0 ACCEPTED, buf1 FILLED, buf2 EMPTY: all three agents act on distinct buffers.
        checks++; if (a_rdy_fwd !== 1'b1 || a_rdy_cpu !== 1'b1 || a_rdy_sn !== 1'b1) begin failures++;
            $display("FAIL sim_pre: got rdy=%b%b%b want 111", a_rdy_sn, a_rdy_cpu, a_rdy_fwd); end
        e = sbq.pop_front();
        checks++; if (a_fwd_sel !== 2'(e.sel) || a_fwd_len !== 13'(e.len)) begin failures++;
            $display("FAIL sim_fwd0: got sel=%0d len=%0d want sel=%0d len=%0d",
                     a_fwd_sel, a_fwd_len, e.sel, e.len); end
        sbq.push_back('{sel: 1, len: 200});
        a_sn_done  = 1'b1;
        a_acc      = 1'b1;
        a_cpu_len  = 13'd200;
        a_fwd_done = 1'b1;
        tick();
        {a_sn_done, a_acc, a_fwd_done} = 3'b000;
        checks++; if (a_occ !== 3'd2) begin failures++;
            $display("FAIL sim_occ: got %0d want 2", a_occ); end
        checks++; if ({a_sn_sel, a_cpu_sel, a_fwd_sel} !== {2'd0, 2'd2, 2'd1}) begin failures++;
            $display("FAIL sim_ptrs: got %0d/%0d/%0d want 0/2/1", a_sn_sel, a_cpu_sel, a_fwd_sel); end
        checks++; if ({a_rdy_sn, a_rdy_cpu, a_rdy_fwd} !== 3'b111) begin failures++;
            $display("FAIL sim_ready: got %b want 111", {a_rdy_sn, a_rdy_cpu, a_rdy_fwd}); end
        drain_a("sim_buf1");
    endtask

    task automatic test_proto_reset();
        // buf2 is FILLED at cpu_ptr=2.
        a_acc     = 1'b1;
        a_rej     = 1'b1;
        a_cpu_len = 13'd333;
        tick();
        {a_acc, a_rej} = 2'b00;
        checks++; if (a_perr !== 1'b1) begin failures++;
            $display("FAIL pe_set: got %b want 1", a_perr); end
        checks++; if (a_rejc !== 16'd2 || a_rdy_fwd !== 1'b0 || a_fwd_sel !== 2'd2) begin failures++;
            $display("FAIL pe_rejected: got rej=%0d rdy_fwd=%b sel=%0d want 2/0/2",
                     a_rejc, a_rdy_fwd, a_fwd_sel); end
        tick();
        checks++; if (a_occ !== 3'd0 || a_fwd_sel !== 2'd0) begin failures++;
            $display("FAIL pe_freed: got occ=%0d sel=%0d want 0/0", a_occ, a_fwd_sel); end
        snoop_a();
        accept_a(77, 1'b0);
        checks++; if (a_perr !== 1'b1 || a_rdy_fwd !== 1'b1) begin failures++;
            $display("FAIL pe_sticky: got perr=%b rdy_fwd=%b want 1/1", a_perr, a_rdy_fwd); end
        a_rst     = 1'b0;
        a_sn_done = 1'b1;
        tick();
        checks++; if ({a_rdy_sn, a_rdy_cpu, a_rdy_fwd} !== 3'b000) begin failures++;
            $display("FAIL mr_ready_low: got %b want 000", {a_rdy_sn, a_rdy_cpu, a_rdy_fwd}); end
        a_rst     = 1'b1;
        a_sn_done = 1'b0;
        #1;
        checks++; if ({a_rdy_sn, a_rdy_cpu, a_rdy_fwd} !== 3'b100) begin failures++;
            $display("FAIL mr_ready: got %b want 100", {a_rdy_sn, a_rdy_cpu, a_rdy_fwd}); end
        checks++; if (a_perr !== 1'b0 || a_occ !== 3'd0) begin failures++;
            $display("FAIL mr_clear: got perr=%b occ=%0d want 0/0", a_perr, a_occ); end
        checks++; if (a_rejc !== 16'd0 || a_drop !== 16'd0) begin failures++;
            $display("FAIL mr_counts: got rej=%0d drop=%0d want 0/0", a_rejc, a_drop); end
        checks++; if ({a_sn_sel, a_cpu_sel, a_fwd_sel} !== 6'd0) begin failures++;
            $display("FAIL mr_sel: got %0d/%0d/%0d want 0/0/0", a_sn_sel, a_cpu_sel, a_fwd_sel); end
    endtask

    task automatic test_wrap5();
        int   fwd_cnt = 0;
        int   n;
        exp_t e;
        b_rst = 1'b1;
        #1;
        for (int p = 0; p < 12; p++) begin
            checks++; if (b_sn_sel !== 3'(p % 5) || b_rdy_sn !== 1'b1) begin failures++;
                $display("FAIL wrap_sn%0d: got sel=%0d rdy=%b want %0d/1", p, b_sn_sel, b_rdy_sn, p % 5); end
            b_sn_done = 1'b1;
            tick();
            b_sn_done = 1'b0;
            checks++; if (b_cpu_sel !== 3'(p % 5) || b_rdy_cpu !== 1'b1) begin failures++;
                $display("FAIL wrap_cpu%0d: got sel=%0d rdy=%b want %0d/1", p, b_cpu_sel, b_rdy_cpu, p % 5); end
            sbq.push_back('{sel: p % 5, len: 10 * p + 7});
            b_acc     = 1'b1;
            b_cpu_len = 13'(10 * p + 7);
            tick();
            b_acc = 1'b0;
            n = 0;
            while (!b_rdy_fwd && n < 8) begin
                tick();
                n++;
            end
            checks++;
            if (!b_rdy_fwd || sbq.size() == 0) begin
                failures++;
                $display("FAIL wrap_fwd%0d: got rdy=%b queued=%0d want rdy=1 with entry",
                         p, b_rdy_fwd, sbq.size());
            end else begin
                e = sbq.pop_front();
                if (b_fwd_sel !== 3'(e.sel) || b_fwd_len !== 13'(e.len)) begin
                    failures++;
                    $display("FAIL wrap_fwd%0d: got sel=%0d len=%0d want sel=%0d len=%0d",
                             p, b_fwd_sel, b_fwd_len, e.sel, e.len);
                end
                fwd_cnt++;
                b_fwd_done = 1'b1;
                tick();
                b_fwd_done = 1'b0;
            end
        end
        checks++; if (fwd_cnt != 12 || sbq.size() != 0 || b_occ !== 4'd0) begin failures++;
            $display("FAIL wrap_total: got fwd=%0d left=%0d occ=%0d want 12/0/0",
                     fwd_cnt, sbq.size(), b_occ); end
        checks++; if ({b_sn_sel, b_cpu_sel, b_fwd_sel} !== {3'd2, 3'd2, 3'd2}) begin failures++;
            $display("FAIL wrap_end_sel: got %0d/%0d/%0d want 2/2/2", b_sn_sel, b_cpu_sel, b_fwd_sel); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_accept_reject();
        test_simultaneous();
        test_proto_reset();
        test_wrap5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/packet_buf_ring.md
Name: packet_buf_ring

Overview:
- Generalised N-way successor to the fixed two-buffer snooper/forwarder ping-pong in bpfvm.
- Owns the state of N_BUFS packet buffers. Hands each buffer in turn to the snooper (fill), then the BPF CPU (filter), then the forwarder (drain).
- Preserves packet order, carries the CPU's accept length through to the forwarder, and counts drops.
- Sits between the snooper/forwarder interfaces and the packetmem select lines.

Parameters:
- N_BUFS, 3, number of packet buffers (≥2; not required to be a power of two).
- PLEN_WIDTH, 13, width of the accepted packet length in bytes (PACKET_BYTE_ADDR_WIDTH+1).
- CNT_WIDTH, 16, width of the statistics counters.
- SELW (localparam), $clog2(N_BUFS), width of the buffer select lines.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- snooper_done  in  1  1-cycle pulse: current snooper buffer is full.
- ready_for_snooper  out  1  snooper buffer is EMPTY.
- snooper_sel  out  SELW  buffer index the snooper writes.
- ready_for_cpu  out  1  cpu buffer is FILLED.
- cpu_sel  out  SELW  buffer index the CPU reads.
- cpu_acc  in  1  1-cycle pulse: accept.
- cpu_rej  in  1  1-cycle pulse: reject.
- cpu_len  in  PLEN_WIDTH  accept length; sampled with cpu_acc.
- ready_for_forwarder  out  1  forwarder buffer is ACCEPTED.
- forwarder_sel  out  SELW  buffer index the forwarder reads.
- forwarder_len  out  PLEN_WIDTH  stored length of the forwarder buffer.
- forwarder_done  in  1  1-cycle pulse: drain complete.
- occupancy  out  SELW+1  count of non-EMPTY buffers.
- drop_count  out  CNT_WIDTH  snooper_done pulses ignored because the buffer was not ready.
- rej_count  out  CNT_WIDTH  buffers rejected.
- proto_err  out  1  sticky; set on simultaneous cpu_acc and cpu_rej.

Behaviour:
- Per-buffer state: EMPTY, FILLED, ACCEPTED, REJECTED, plus a stored length.
- Three ring pointers: sn_ptr, cpu_ptr, fwd_ptr.
  - Each increments by 1 and wraps from N_BUFS-1 to 0.
  - The *_sel outputs are the pointers, driven directly.
- Ready outputs are combinational from registered state at the pointer:
  - ready_for_snooper = state[sn_ptr]==EMPTY
  - ready_for_cpu = state[cpu_ptr]==FILLED
  - ready_for_forwarder = state[fwd_ptr]==ACCEPTED
  - All ready outputs are forced to 0 while rst is low.
- Reset (rst low at a clk edge):
  - All buffers EMPTY, lengths 0, pointers 0, counters 0, proto_err 0.
  - First cycle after reset: ready_for_snooper=1; other ready outputs 0; occupancy 0.
  - Reset mid-operation discards every buffer and any in-flight pulse.
- snooper_done with ready_for_snooper: state[sn_ptr] goes FILLED and sn_ptr advances. Both are visible next cycle (1-cycle latency).
- snooper_done without ready_for_snooper: no state change; drop_count increments.
- cpu_acc with ready_for_cpu: state goes ACCEPTED, len<=cpu_len, cpu_ptr advances.
- cpu_rej with ready_for_cpu: state goes REJECTED, cpu_ptr advances, rej_count increments.
- cpu_acc and cpu_rej in the same cycle: treated as reject; proto_err is set and held until reset.
- CPU pulses without ready_for_cpu are ignored.
- Forwarder pointer:
  - If state[fwd_ptr]==REJECTED, the block frees it autonomously in 1 cycle: EMPTY, fwd_ptr advances, ready_for_forwarder stays 0. This skips rejects in order.
  - forwarder_done with ready_for_forwarder: EMPTY, fwd_ptr advances.
  - forwarder_done without ready_for_forwarder is ignored.
- Simultaneous events:
  - Two pointers can share a buffer only when that buffer's states are mutually exclusive for their actions.
  - All three agents' actions therefore commit in the same cycle independently.
  - occupancy is updated by the net +1/−1 sum of those actions.
- Counters saturate at all-ones; no wrap.
- forwarder_len is the stored length of buffer fwd_ptr, valid whenever ready_for_forwarder=1.

Decomposition:
- Shared package bpf_pkg:
  - buf_state_t enum {EMPTY, FILLED, ACCEPTED, REJECTED}.
  - PACKET_BYTE_ADDR_WIDTH and the derived PLEN width constant.
- One natural sub-module: ring_ptr.
  - Parameter N; inputs clk, rst, adv; output ptr.
  - Modulo-N counter, instantiated three times.
- The saturating counter stays inline.

Test Plan:
- Reset then fill: rst low 2 cycles, release, 3 snooper_done pulses 2 cycles apart (N_BUFS=3).
  - Required: snooper_sel 0→1→2; occupancy 3; ready_for_snooper=0; ready_for_cpu=1 with cpu_sel=0.
- Overflow: with all 3 buffers FILLED, 2 further snooper_done pulses.
  - Required: drop_count=2; no state change.
- Accept/reject ordering:
  - Stimulus: cpu_acc len=64 on buf0, cpu_rej on buf1, cpu_acc len=1500 on buf2.
  - Required: forwarder sees buf0 with len 64; forwarder_done; buf1 auto-freed within 1 cycle without ready; then buf2 with len 1500; rej_count=1; occupancy 0.
- Wrap with N_BUFS=5 (non-power-of-2): run 12 packets end to end.
  - Required: each *_sel sequence is 0,1,2,3,4,0,…; all 12 forwarded in order.
- Simultaneous events: snooper_done, cpu_acc and forwarder_done in the same cycle on three different buffers.
  - Required: all three commit next cycle; occupancy unchanged.
- Protocol error then mid-operation reset: cpu_acc and cpu_rej together.
  - Required: buffer marked REJECTED; proto_err=1.
  - Then rst low for 1 cycle mid-forward: all state cleared; proto_err=0; ready_for_snooper=1.
